// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and legality helper for the data-memory responder.
`default_nettype none

package dmem_pkg;

  typedef enum logic [2:0] {
    LS_B  = 3'b000,
    LS_H  = 3'b001,
    LS_W  = 3'b010,
    LS_BU = 3'b100,
    LS_HU = 3'b101
  } ls_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Unsigned modes only make sense for loads.
  function automatic logic is_legal(input logic [2:0] mode, input logic we);
    logic ok;
    case (mode)
      LS_B, LS_H, LS_W: ok = 1'b1;
      LS_BU, LS_HU:     ok = ~we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: little-endian lane steering for stores and lane select plus extension for loads.
`default_nettype none

module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  ls_mode_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    be_o    = 4'b0000;
    wdata_o = wdata_i;
    case (ls_mode_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << lane_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_o    = lane_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
      end
      2'b10:   be_o = 4'b1111;
      default: be_o = 4'b0000;
    endcase
  end

  always_comb begin
    w_byte = rword_i[8*lane_i +: 8];
    w_half = lane_i[1] ? rword_i[31:16] : rword_i[15:0];
    case (ls_mode_i)
      LS_B:    rdata_o = {{24{w_byte[7]}}, w_byte};
      LS_H:    rdata_o = {{16{w_half[15]}}, w_half};
      LS_W:    rdata_o = rword_i;
      LS_BU:   rdata_o = {24'h0, w_byte};
      LS_HU:   rdata_o = {16'h0, w_half};
      default: rdata_o = 32'h0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle valid/ready data memory with byte/half/word access.
// Define DMEM_MISALIGN_TRAP_EN to report misaligned accesses as errors instead of aligning them.
`default_nettype none

module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [2:0]  req_ls_mode_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        busy_o
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        req_ready_q, rsp_valid_q, rsp_err_q, busy_q;
  logic [31:0] rsp_rdata_q;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [2:0]  mode_q;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [31:0] offset_d;
  logic [IDX_W-1:0] idx_d;
  logic        in_range_d, misaligned_d, err_d, access_d, write_d;
  logic [1:0]  lane_d;
  logic [31:0] rword_d, rdata_ext_d, wdata_al_d, rsp_rdata_d;
  logic [3:0]  be_d;

  always_comb begin
    offset_d     = addr_q - BASE_ADDR;
    idx_d        = offset_d[IDX_W+1:2];
    in_range_d   = (addr_q >= BASE_ADDR) && ({2'b00, offset_d[31:2]} < 32'(DEPTH_WORDS));
    misaligned_d = ((mode_q[1:0] == 2'b01) && offset_d[0]) ||
                   ((mode_q[1:0] == 2'b10) && (offset_d[1:0] != 2'b00));
`ifdef DMEM_MISALIGN_TRAP_EN
    lane_d = offset_d[1:0];
    err_d  = !is_legal(mode_q, we_q) || !in_range_d || misaligned_d;
`else
    // Misaligned halves/words silently snap to their natural boundary.
    case (mode_q[1:0])
      2'b01:   lane_d = {offset_d[1], 1'b0};
      2'b10:   lane_d = 2'b00;
      default: lane_d = offset_d[1:0];
    endcase
    err_d = !is_legal(mode_q, we_q) || !in_range_d || (misaligned_d && 1'b0);
`endif
    rword_d     = in_range_d ? mem_q[idx_d] : 32'h0;
    access_d    = (state_q == WAIT) && (cnt_q == 4'd0);
    write_d     = access_d && we_q && !err_d;
    rsp_rdata_d = (we_q || err_d) ? 32'h0 : rdata_ext_d;
  end

  dmem_lane_align u_lane_align (
    .ls_mode_i (mode_q),
    .lane_i    (lane_d),
    .wdata_i   (wdata_q),
    .rword_i   (rword_d),
    .be_o      (be_d),
    .wdata_o   (wdata_al_d),
    .rdata_o   (rdata_ext_d)
  );

  // Storage has no reset; a write only fires from WAIT, so reset cancels pending stores.
  always_ff @(posedge clk_i) begin
    if (write_d) begin
      for (int b = 0; b < 4; b++) begin
        if (be_d[b]) mem_q[idx_d][8*b +: 8] <= wdata_al_d[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      mode_q      <= 3'b000;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            we_q        <= req_we_i;
            addr_q      <= req_addr_i;
            wdata_q     <= req_wdata_i;
            mode_q      <= req_ls_mode_i;
            cnt_q       <= 4'(LATENCY - 1);
            state_q     <= WAIT;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= err_d;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign busy_o      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: table-driven, scoreboarded checks of dmem_responder at LATENCY=2.
`default_nettype none
`timescale 1ns/1ps

module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [2:0]  req_ls_mode = 3'b000;
  logic        rsp_ready = 1'b0;
  logic        req_ready, rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata;

  dmem_responder #(
    .DEPTH_WORDS (1024),
    .BASE_ADDR   (32'h0001_0000),
    .LATENCY     (LAT)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_we_i      (req_we),
    .req_addr_i    (req_addr),
    .req_wdata_i   (req_wdata),
    .req_ls_mode_i (req_ls_mode),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_rdata_o   (rsp_rdata),
    .rsp_err_o     (rsp_err),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  mode;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [2:0] mode,
                     input logic [31:0] rdata, input logic err);
    vec_t v;
    v.name = name; v.we = we; v.addr = addr; v.wdata = wdata;
    v.mode = mode; v.rdata = rdata; v.err = err;
    vecs.push_back(v);
  endtask

  task automatic drive_req(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [2:0] mode);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_ls_mode = mode;
  endtask

  // Waits for the handshake, then counts edges until the response shows up.
  task automatic accept_and_wait(input string name, input logic [31:0] erd, input logic eerr);
    int n;
    exp_t e;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    check({name, " accept"}, {31'h0, req_ready}, 32'h1);
    e.rdata = erd; e.err = eerr;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    check({name, " latency"}, n, LAT);
  endtask

  task automatic compare_rsp(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: response with empty scoreboard", name);
    end else begin
      e = sb.pop_front();
      check({name, " rdata"}, rsp_rdata, e.rdata);
      check({name, " err"}, {31'h0, rsp_err}, {31'h0, e.err});
    end
  endtask

  task automatic retire(input string name);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({name, " retire"}, {29'h0, rsp_valid, req_ready, busy}, 32'b010);
  endtask

  task automatic xact(input string name, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [2:0] mode,
                      input logic [31:0] erd, input logic eerr);
    @(negedge clk);
    drive_req(we, addr, wdata, mode);
    accept_and_wait(name, erd, eerr);
    compare_rsp(name);
    retire(name);
  endtask

  initial begin
    logic [31:0] mis_rd;
    logic        mis_err;
`ifdef DMEM_MISALIGN_TRAP_EN
    mis_rd = 32'h0; mis_err = 1'b1;
`else
    mis_rd = 32'h8765_4321; mis_err = 1'b0;
`endif

    add("sw_base",   1, 32'h0001_0004, 32'h8765_4321, 3'b010, 32'h0,          0);
    add("lw_base",   0, 32'h0001_0004, 32'h0,         3'b010, 32'h8765_4321, 0);
    add("lb_neg",    0, 32'h0001_0007, 32'h0,         3'b000, 32'hFFFF_FF87, 0);
    add("lbu",       0, 32'h0001_0007, 32'h0,         3'b100, 32'h0000_0087, 0);
    add("lh_neg",    0, 32'h0001_0006, 32'h0,         3'b001, 32'hFFFF_8765, 0);
    add("lhu",       0, 32'h0001_0004, 32'h0,         3'b101, 32'h0000_4321, 0);
    add("lw_mis",    0, 32'h0001_0006, 32'h0,         3'b010, mis_rd,        mis_err);
    add("sb_lane1",  1, 32'h0001_0005, 32'h0000_00AA, 3'b000, 32'h0,          0);
    add("lw_after_sb",0,32'h0001_0004, 32'h0,         3'b010, 32'h8765_AA21, 0);
    add("lw_below",  0, 32'h0000_0100, 32'h0,         3'b010, 32'h0,          1);
    add("sw_w2",     1, 32'h0001_0008, 32'h1111_1111, 3'b010, 32'h0,          0);
    add("ld_ill011", 0, 32'h0001_0004, 32'h0,         3'b011, 32'h0,          1);
    add("st_ill101", 1, 32'h0001_0004, 32'h0000_FFFF, 3'b101, 32'h0,          1);
    add("lw_nowrite",0, 32'h0001_0004, 32'h0,         3'b010, 32'h8765_AA21, 0);
    add("lw_above",  0, 32'h0001_1000, 32'h0,         3'b010, 32'h0,          1);
    add("sw_last",   1, 32'h0001_0FFC, 32'hCAFE_F00D, 3'b010, 32'h0,          0);
    add("lw_last",   0, 32'h0001_0FFC, 32'h0,         3'b010, 32'hCAFE_F00D, 0);
    add("sh_lane2",  1, 32'h0001_000A, 32'h1234_BEEF, 3'b001, 32'h0,          0);
    add("lw_after_sh",0,32'h0001_0008, 32'h0,         3'b010, 32'hBEEF_1111, 0);
    add("lh_hi",     0, 32'h0001_000A, 32'h0,         3'b001, 32'hFFFF_BEEF, 0);

    // Reset state
    repeat (3) @(negedge clk);
    check("reset outs", {27'h0, req_ready, rsp_valid, rsp_err, busy, 1'b0}, {27'h0, 5'b10000});
    check("reset rdata", rsp_rdata, 32'h0);
    rst_ni = 1'b1;

    foreach (vecs[i])
      xact(vecs[i].name, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].mode,
           vecs[i].rdata, vecs[i].err);

    // Hold response for 5 cycles while a competing request waits
    @(negedge clk);
    drive_req(1'b0, 32'h0001_0004, 32'h0, 3'b010);
    accept_and_wait("hold", 32'h8765_AA21, 1'b0);
    drive_req(1'b1, 32'h0001_0004, 32'h0, 3'b010);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold valid", {30'h0, rsp_valid, req_ready}, 32'b10);
      check("hold rdata", rsp_rdata, 32'h8765_AA21);
    end
    compare_rsp("hold");
    req_valid = 1'b0;
    retire("hold");
    xact("lw_not_stored", 0, 32'h0001_0004, 32'h0, 3'b010, 32'h8765_AA21, 0);

    // Reset in the middle of WAIT drops the pending store
    xact("sw_1111", 1, 32'h0001_0008, 32'h1111_1111, 3'b010, 32'h0, 0);
    @(negedge clk);
    drive_req(1'b1, 32'h0001_0008, 32'hDEAD_BEEF, 3'b010);
    @(negedge clk);
    req_valid = 1'b0;
    check("midwait busy", {31'h0, busy}, 32'h1);
    #2 rst_ni = 1'b0;
    #1;
    check("midrst outs", {28'h0, req_ready, rsp_valid, rsp_err, busy}, 32'b1000);
    check("midrst rdata", rsp_rdata, 32'h0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    xact("lw_after_rst", 0, 32'h0001_0008, 32'h0, 3'b010, 32'h1111_1111, 0);

    check("sb drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
